// File: rtl/lmc_pkg.sv
// -----------------------------------------------------------------------------
// lmc_pkg
// Definitions shared by the LMC data memory and its storage array.
//   lmc_ram_state_t : two-state controller encoding (CLEAR sweep / IDLE service)
//   LMC_DW, LMC_AW  : default data and address widths of the LMC main store
//   lmc_parity()    : even-parity bit over a zero-extended data word
// -----------------------------------------------------------------------------
package lmc_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } lmc_ram_state_t;

   localparam int LMC_DW = 4;
   localparam int LMC_AW = 2;

   // Widest word lmc_parity() accepts; callers zero-extend, which leaves the
   // parity of the real data bits unchanged.
   localparam int LMC_PAR_W = 64;

   // Returns the bit that makes the XOR of data plus parity equal to zero.
   function automatic logic lmc_parity(input logic [LMC_PAR_W-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/lmc_ram_array.sv
// -----------------------------------------------------------------------------
// lmc_ram_array
// Bare storage for lmc_ram: DEPTH words of WW bits, one write port and one
// registered read port sharing the clock. A read and write to the same address
// on the same edge returns the write data (write-first), which is how the top
// level obtains its write-through result.
//
// Ports
//   clk    in   clock
//   rst    in   asynchronous active-high reset (read register only)
//   we     in   write enable
//   wadr   in   write address
//   wdata  in   write word
//   re     in   read enable; rdata holds its value while low
//   radr   in   read address
//   rdata  out  registered read word
// -----------------------------------------------------------------------------
module lmc_ram_array
   import lmc_pkg::*;
#(
   parameter int WW = LMC_DW,
   parameter int AW = LMC_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] wadr,
   input  logic [WW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] radr,
   output logic [WW-1:0] rdata
);

   localparam int DEPTH = 1 << AW;

   logic [WW-1:0] mem [DEPTH];

   // NOTE: the storage has no reset branch so it maps onto plain RAM cells;
   // the controller's clear sweep is what gives the words a defined value.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wadr] <= wdata;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= (we && (wadr == radr)) ? wdata : mem[radr];
      end
   end

endmodule

// File: rtl/lmc_ram.sv
// -----------------------------------------------------------------------------
// lmc_ram
// Single-port synchronous data memory for the LMC datapath. After reset, or on
// a clr request taken in IDLE, a hardware sweep writes CLR_VAL to every word
// (busy=1 for DEPTH cycles). In IDLE every req is accepted, and ack pulses one
// cycle later with RAM_out holding the read word or the written word.
//
// Configuration macro: LMC_RAM_PARITY_EN
//   defined   : each word stores an even-parity bit; par_err flags a mismatch
//               on the word returned with ack
//   undefined : DW-bit storage, par_err tied low
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   req      in   access request, taken while ready=1
//   we       in   1 = write, 0 = read
//   adr      in   word address
//   data_in  in   write data
//   clr      in   start a clear sweep, taken while ready=1
//   ready    out  controller is idle and accepts a request
//   busy     out  clear sweep in progress
//   ack      out  one-cycle pulse after each accepted request
//   RAM_out  out  registered read / write-through data
//   par_err  out  parity mismatch on the word returned with ack
// -----------------------------------------------------------------------------
module lmc_ram
   import lmc_pkg::*;
#(
   parameter int            DW      = LMC_DW,
   parameter int            AW      = LMC_AW,
   parameter logic [DW-1:0] CLR_VAL = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req,
   input  logic          we,
   input  logic [AW-1:0] adr,
   input  logic [DW-1:0] data_in,
   input  logic          clr,
   output logic          ready,
   output logic          busy,
   output logic          ack,
   output logic [DW-1:0] RAM_out,
   output logic          par_err
);

   localparam int            DEPTH    = 1 << AW;
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

`ifdef LMC_RAM_PARITY_EN
   localparam int WW = DW + 1;
`else
   localparam int WW = DW;
`endif

   lmc_ram_state_t state;
   logic [AW-1:0]  clr_ptr;

   logic           arr_we;
   logic [AW-1:0]  arr_wadr;
   logic [DW-1:0]  arr_wdat;
   logic [WW-1:0]  arr_wword;
   logic           arr_re;
   logic [WW-1:0]  arr_rword;

   assign ready = (state == IDLE);
   assign busy  = (state == CLEAR);

   // ---------------------------------------------------------------------------
   // Controller: sweep pointer, state and ack pulse
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= CLEAR;
         clr_ptr <= '0;
         ack     <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               ack <= 1'b0;
               // The pointer stops on the last word instead of wrapping; it is
               // rearmed to 0 while IDLE.
               if (clr_ptr == LAST_PTR) begin
                  state <= IDLE;
               end else begin
                  clr_ptr <= clr_ptr + AW'(1);
               end
            end
            default: begin
               ack     <= req;
               clr_ptr <= '0;
               if (clr) begin
                  state <= CLEAR;
               end
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Storage port steering: the sweep owns the write port while busy, otherwise
   // an accepted request drives both ports at the same address so a write
   // comes straight back on the read register.
   // ---------------------------------------------------------------------------
   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      arr_we   = 1'b0;
      arr_wadr = adr;
      arr_wdat = data_in;
      arr_re   = 1'b0;
      if (state == CLEAR) begin
         arr_we   = 1'b1;
         arr_wadr = clr_ptr;
         arr_wdat = CLR_VAL;
      end else if (req) begin
         arr_we = we;
         arr_re = 1'b1;
      end
   end

`ifdef LMC_RAM_PARITY_EN
   assign arr_wword = {lmc_parity(LMC_PAR_W'(arr_wdat)), arr_wdat};
   // A written word carries freshly computed parity, so write-through data can
   // never report an error; only a corrupted stored word can.
   assign par_err   = lmc_parity(LMC_PAR_W'(arr_rword[DW-1:0])) ^ arr_rword[DW];
`else
   assign arr_wword = arr_wdat;
   assign par_err   = 1'b0;
`endif

   assign RAM_out = arr_rword[DW-1:0];

   lmc_ram_array #(
      .WW (WW),
      .AW (AW)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .we    (arr_we),
      .wadr  (arr_wadr),
      .wdata (arr_wword),
      .re    (arr_re),
      .radr  (adr),
      .rdata (arr_rword)
   );

endmodule
